// File: rtl/breakout_pkg.sv
// Shared definitions for the breakout game controller: phase codes,
// overlay message codes and default game parameters.
package breakout_pkg;

  localparam logic [2:0] ST_NEWGAME = 3'd0;
  localparam logic [2:0] ST_PLAY    = 3'd1;
  localparam logic [2:0] ST_NEWBALL = 3'd2;
  localparam logic [2:0] ST_OVER    = 3'd3;
  localparam logic [2:0] ST_WIN     = 3'd4;

  localparam logic [1:0] MSG_NONE  = 2'd0;
  localparam logic [1:0] MSG_START = 2'd1;
  localparam logic [1:0] MSG_OVER  = 2'd2;
  localparam logic [1:0] MSG_WIN   = 2'd3;

  localparam int TIMER_FRAMES_DEFAULT = 120;
  localparam int LIVES_INIT_DEFAULT   = 3;

  // Text overlay shown while the game sits in a given phase.
  function automatic logic [1:0] msg_for_state(input logic [2:0] st);
    logic [1:0] m;
    case (st)
      ST_NEWGAME: m = MSG_START;
      ST_OVER:    m = MSG_OVER;
      ST_WIN:     m = MSG_WIN;
      default:    m = MSG_NONE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/breakout_game_ctrl_if.sv
// Signal bundle between the graphics datapath / player inputs and the
// game controller. The controller takes the slave side.
interface breakout_game_ctrl_if;
  logic        frame_tick;
  logic [4:0]  btn;
  logic        hit;
  logic        miss;
  logic        all_cleared;
  logic        gra_still;
  logic [15:0] score;
  logic [1:0]  lives;
  logic [1:0]  msg_sel;
  logic        timer_busy;

  modport master (
    output frame_tick, btn, hit, miss, all_cleared,
    input  gra_still, score, lives, msg_sel, timer_busy
  );

  modport slave (
    input  frame_tick, btn, hit, miss, all_cleared,
    output gra_still, score, lives, msg_sel, timer_busy
  );
endinterface

// File: rtl/breakout_game_ctrl_bcd.sv
// Four-digit packed BCD score counter: synchronous clear, +1 on enable,
// sticks at 9999 instead of wrapping.
module bcd_score_counter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [15:0] score_o
);

  logic [15:0] score_q, score_d;
  logic        carry;
  logic [3:0]  digit;

  // Ripple a +1 through the digits; a digit at 9 rolls to 0 and passes the carry up.
  always_comb begin
    score_d = score_q;
    carry   = 1'b0;
    digit   = 4'd0;
    if (clr_i) begin
      score_d = 16'h0000;
    end else if (inc_i && score_q != 16'h9999) begin
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
        digit = score_q[4*i +: 4];
        if (carry) begin
          if (digit == 4'd9) begin
            score_d[4*i +: 4] = 4'd0;
          end else begin
            score_d[4*i +: 4] = digit + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  // Score register, cleared immediately by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) score_q <= 16'h0000;
    else          score_q <= score_d;
  end

  assign score_o = score_q;

endmodule

// File: rtl/breakout_game_ctrl.sv
// Breakout game sequencer: phase FSM, frame-based pause timer, lives
// bookkeeping and registered display controls. Score lives in the
// bcd_score_counter sub-block.
module breakout_game_ctrl
  import breakout_pkg::*;
#(
  parameter int TIMER_FRAMES = TIMER_FRAMES_DEFAULT,
  parameter int LIVES_INIT   = LIVES_INIT_DEFAULT
) (
  input  logic                clk,
  input  logic                reset_n,
  breakout_game_ctrl_if.slave bus
);

  logic [2:0]  state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [1:0]  lives_q, lives_d;
  logic        gra_still_q;
  logic [1:0]  msg_sel_q;
  logic        timer_busy_q;
  logic        timer_load;
  logic        any_btn;
  logic        score_clr, score_inc;
  logic [15:0] score_w;

  assign any_btn = |bus.btn;

  // Next phase, timer and lives; a timer load overrides a same-cycle frame tick.
  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    timer_load = 1'b0;
    timer_d    = timer_q;
    if (bus.frame_tick && timer_q != 16'd0) timer_d = timer_q - 16'd1;
    case (state_q)
      ST_NEWGAME: begin
        if (any_btn) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (bus.all_cleared) begin
          state_d    = ST_WIN;
          timer_load = 1'b1;
        end else if (bus.miss) begin
          timer_load = 1'b1;
          if (lives_q <= 2'd1) begin
            lives_d = 2'd0;
            state_d = ST_OVER;
          end else begin
            lives_d = lives_q - 2'd1;
            state_d = ST_NEWBALL;
          end
        end
      end
      ST_NEWBALL: begin
        if (timer_q == 16'd0 && any_btn) state_d = ST_PLAY;
      end
      ST_OVER, ST_WIN: begin
        if (timer_q == 16'd0) state_d = ST_NEWGAME;
      end
      default: state_d = ST_NEWGAME;
    endcase
    if (timer_load) timer_d = TIMER_FRAMES[15:0];
    if (state_d == ST_NEWGAME) lives_d = LIVES_INIT[1:0];
  end

  assign score_clr = (state_d == ST_NEWGAME);
  assign score_inc = (state_q == ST_PLAY) && bus.hit;

  // State, timer and display controls; outputs are derived from next-state so they land one edge after the cause.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_NEWGAME;
      timer_q      <= 16'd0;
      lives_q      <= LIVES_INIT[1:0];
      gra_still_q  <= 1'b1;
      msg_sel_q    <= MSG_START;
      timer_busy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      lives_q      <= lives_d;
      gra_still_q  <= (state_d != ST_PLAY);
      msg_sel_q    <= msg_for_state(state_d);
      timer_busy_q <= (timer_d != 16'd0);
    end
  end

  bcd_score_counter u_score (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (score_clr),
    .inc_i   (score_inc),
    .score_o (score_w)
  );

  assign bus.gra_still  = gra_still_q;
  assign bus.msg_sel    = msg_sel_q;
  assign bus.lives      = lives_q;
  assign bus.timer_busy = timer_busy_q;
  assign bus.score      = score_w;

endmodule

// File: doc/breakout_game_ctrl.md
BREAKOUT_GAME_CTRL -- requirements
Module: breakout_game_ctrl

Interface
REQ-001 Parameter: TIMER_FRAMES, default 120, frame count of the pause between game phases (2 s at 60 Hz).
REQ-002 Parameter: LIVES_INIT, default 3, number of balls per game.
REQ-003 Port: clk  input  1  system clock; the single clock of the block.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: frame_tick  input  1  one-cycle pulse per screen refresh (start of v-sync).
REQ-006 Port: btn  input  5  player buttons, already debounced; "any pressed" = OR of all bits.
REQ-007 Port: hit  input  1  one-cycle pulse from the graphics datapath when a brick is destroyed.
REQ-008 Port: miss  input  1  one-cycle pulse from the graphics datapath when the ball leaves play.
REQ-009 Port: all_cleared  input  1  level, high when no bricks remain.
REQ-010 Port: gra_still  output  1  freezes the ball and paddle and restores bricks/positions when high.
REQ-011 Port: score  output  16  four packed BCD digits, most-significant digit in [15:12].
REQ-012 Port: lives  output  2  remaining balls.
REQ-013 Port: msg_sel  output  2  text overlay select: 0 none, 1 start, 2 game over, 3 win.
REQ-014 Port: timer_busy  output  1  high while the phase timer is non-zero.

Function
REQ-015 State machine SHALL have five states: NEWGAME, PLAY, NEWBALL, OVER and WIN.
REQ-016 NEWGAME: gra_still=1, msg_sel=1, score cleared to 0000, lives loaded with LIVES_INIT; any button -> PLAY on the next cycle.
REQ-017 PLAY: gra_still=0, msg_sel=0.
REQ-018 PLAY, all_cleared high -> WIN and the timer loads TIMER_FRAMES; this has priority over a miss in the same cycle.
REQ-019 PLAY, miss with lives==1 -> OVER, lives=0, and the timer loads TIMER_FRAMES.
REQ-020 PLAY, miss with lives>1 -> NEWBALL, lives decrements, and the timer loads TIMER_FRAMES.
REQ-021 NEWBALL: gra_still=1, msg_sel=0; -> PLAY only when the timer is 0 and any button is pressed; a button pressed while the timer is non-zero is ignored.
REQ-022 OVER (msg_sel=2) and WIN (msg_sel=3): gra_still=1; -> NEWGAME when the timer reaches 0.
REQ-023 Timer SHALL decrement by 1 only on a frame_tick while non-zero, and SHALL hold at 0.
REQ-024 A timer load in the same cycle as a frame_tick SHALL win (value = TIMER_FRAMES).
REQ-025 hit in PLAY SHALL increment score by 1 in BCD, with each digit carrying 9->0.
REQ-026 score SHALL saturate at 9999.
REQ-027 A hit on the same cycle as a miss or all_cleared SHALL still be counted.
REQ-028 hit and miss outside PLAY SHALL be ignored.
REQ-029 All outputs SHALL be registered and change on the clock edge after the causing input, i.e. one-cycle latency.
REQ-030 lives SHALL never underflow below 0.

Reset
REQ-031 While reset_n=0: state=NEWGAME, gra_still=1, msg_sel=1, score=0000, lives=LIVES_INIT, timer=0, timer_busy=0.
REQ-032 Reset asserted mid-operation SHALL abort immediately, with no pending score or lives update surviving.
REQ-033 First state after deassertion SHALL be NEWGAME.

Structure
REQ-034 Shared package breakout_pkg SHALL hold the state enumeration, the msg_sel encodings and the defaults for LIVES_INIT and TIMER_FRAMES.
REQ-035 One sub-module, bcd_score_counter, SHALL implement the 4-digit saturating BCD incrementer with synchronous clear and increment enable.
REQ-036 The timer and FSM SHALL reside in breakout_game_ctrl; the target is 150-300 lines of RTL.

Verification
REQ-037 Release reset, press btn=5'h01 -> next cycle state=PLAY, gra_still=0, lives=3, score=0000.
REQ-038 PLAY, 19 hit pulses -> score=16'h0019; from 16'h0099, one hit -> 16'h0100; from 16'h9999, one hit -> 16'h9999.
REQ-039 PLAY, lives=3, miss -> NEWBALL, lives=2, timer_busy=1; button at frame 60 ignored; after 120 frame_ticks plus a button -> PLAY.
REQ-040 PLAY, lives=1, miss -> OVER, msg_sel=2, lives=0; after 120 frame_ticks -> NEWGAME, score=0000, lives=3.
REQ-041 PLAY, all_cleared, miss and hit asserted together -> WIN, msg_sel=3, lives unchanged, score +1.
REQ-042 Pull reset_n low during NEWBALL with timer=50 -> outputs take their reset values asynchronously, before the next clock edge.
